vend_sequencer: RTL

Transaction controller for the vending machine: accumulates debounced nickel/dime credit, requests a product from the dispenser over a req/ack handshake, then returns change one nickel at a time. Sits between the debouncers (which feed it single-cycle coin pulses) and the dispense/change-return mechanisms. It replaces the bare sell/return outputs with a sequenced, handshaked transaction that is safe against refunds.

---
 rtl/vend_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending transaction controller.
// Accumulates nickel/dime credit, requests a dispense over req/ack, then
// returns change one nickel per pulse with CHG_GAP idle cycles in between.
// Optional feature macro: VEND_TIMEOUT_EN (dispense-ack timeout with sticky fault).
//
// Handshake: disp_req is a level that rises on entry to DISPENSE and stays
// high until the first cycle disp_ack is seen high while disp_req is high
// (or, with the timeout feature, until the timeout expires). disp_ack at any
// other time carries no meaning and is ignored.
module vend_sequencer #(
    parameter int PRICE_N     = 3,
    parameter int CHG_GAP     = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel,
    input  logic       dime,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       chg_pulse,
    output logic [3:0] credit,
    output logic       coin_inhibit,
    output logic       fault,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

`ifdef VEND_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int GW = $clog2(CHG_GAP + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0]    PRICE    = 4'(PRICE_N);
    localparam logic [GW-1:0] GAP_MAX  = GW'(CHG_GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [3:0]    credit_n;
    logic [3:0]    sum;
    logic [3:0]    rem;
    logic          disp_req_n, chg_pulse_n, coin_inhibit_n, fault_n;

    assign dbg_state = state;

    // State and all Moore outputs are registered; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            gap_cnt      <= '0;
            tmo_cnt      <= '0;
            credit       <= '0;
            disp_req     <= 1'b0;
            chg_pulse    <= 1'b0;
            coin_inhibit <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            gap_cnt      <= gap_n;
            tmo_cnt      <= tmo_n;
            credit       <= credit_n;
            disp_req     <= disp_req_n;
            chg_pulse    <= chg_pulse_n;
            coin_inhibit <= coin_inhibit_n;
            fault        <= fault_n;
        end
    end

    // Next-state and next-output logic; every change pulse decrements credit
    // in the same cycle, so the pulse cycle already shows the reduced credit.
    always_comb begin
        state_n     = state;
        gap_n       = gap_cnt;
        tmo_n       = tmo_cnt;
        credit_n    = credit;
        disp_req_n  = 1'b0;
        chg_pulse_n = 1'b0;
        fault_n     = fault;
        sum         = credit + {3'b000, nickel} + {2'b00, dime, 1'b0};
        rem         = credit - PRICE;

        case (state)
            COLLECT: begin
                // Coins are added before a same-cycle cancel refunds the total.
                if (cancel && (sum != 4'd0)) begin
                    state_n     = CHANGE;
                    credit_n    = sum - 4'd1;
                    chg_pulse_n = 1'b1;
                    gap_n       = '0;
                end else begin
                    credit_n = sum;
                    if (sum >= PRICE) begin
                        state_n    = DISPENSE;
                        disp_req_n = 1'b1;
                        tmo_n      = '0;
                    end
                end
            end

            DISPENSE: begin
                disp_req_n = 1'b1;
                tmo_n      = tmo_cnt + 1'b1;
                if (disp_ack) begin
                    disp_req_n = 1'b0;
                    if (rem != 4'd0) begin
                        state_n     = CHANGE;
                        credit_n    = rem - 4'd1;
                        chg_pulse_n = 1'b1;
                        gap_n       = '0;
                    end else begin
                        state_n  = COLLECT;
                        credit_n = 4'd0;
                    end
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    // No ack in time: give the whole credit back.
                    disp_req_n  = 1'b0;
                    fault_n     = 1'b1;
                    state_n     = CHANGE;
                    credit_n    = credit - 4'd1;
                    chg_pulse_n = 1'b1;
                    gap_n       = '0;
                end
            end

            CHANGE: begin
                if (credit == 4'd0) begin
                    state_n = COLLECT;
                end else if (gap_cnt == GAP_MAX) begin
                    chg_pulse_n = 1'b1;
                    credit_n    = credit - 4'd1;
                    gap_n       = '0;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_n  = COLLECT;
                credit_n = 4'd0;
            end
        endcase

        coin_inhibit_n = (state_n != COLLECT);
    end

endmodule
